// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - block-in / ciphertext-out handshake bundle for aes_round_sequencer
//
// Purpose: groups the PT/KEY input handshake and the CT output handshake.
// Byte 0 of every 128-bit block is the most significant byte (bits 127:120),
// i.e. the first byte of the usual big-endian hex string.
//   in_valid  : producer -> sequencer, pt_i/key_i valid
//   in_ready  : sequencer -> producer, block can be accepted this cycle
//   pt_i      : plaintext
//   key_i     : cipher key
//   out_valid : sequencer -> consumer, ct_o holds a finished block
//   out_ready : consumer -> sequencer, ct_o accepted
//   ct_o      : ciphertext
// Modports: slave = sequencer side, master = producer/consumer side.
interface aes_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt_i;
    logic [127:0] key_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct_o;

    modport slave (
        input  in_valid, pt_i, key_i, out_ready,
        output in_ready, out_valid, ct_o
    );

    modport master (
        output in_valid, pt_i, key_i, out_ready,
        input  in_ready, out_valid, ct_o
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 round controller driving an external round unit
//
// Purpose: owns the 128-bit state and round-key registers, loads PT^KEY on
// accept, then steps an external combinational round unit NR times
// (RND_CYC clocks per round) and presents the ciphertext with valid/ready.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   bus          : PT/KEY in and CT out handshakes (slave modport)
//   busy         : rounds in progress
//   rnd_state_o  : current state to the round unit
//   rnd_key_o    : previous round key (round r-1) to the round unit
//   rnd_num_o    : current round 1..NR (rcon select), 0 when not running
//   rnd_last_o   : final round (round unit skips MixColumns)
//   rnd_state_i  : next state from the round unit
//   rnd_key_i    : round key r from the round unit
module aes_round_sequencer #(
    parameter int NR      = 10,
    parameter int RND_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_round_sequencer_if.slave    bus,
    output logic                    busy,
    output logic [127:0]            rnd_state_o,
    output logic [127:0]            rnd_key_o,
    output logic [3:0]              rnd_num_o,
    output logic                    rnd_last_o,
    input  logic [127:0]            rnd_state_i,
    input  logic [127:0]            rnd_key_i
);

    localparam int               CYC_W     = (RND_CYC > 1) ? $clog2(RND_CYC) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(RND_CYC - 1);
    localparam logic [3:0]       RND_FINAL = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [127:0]     state_q, state_d;
    logic [127:0]     key_q, key_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            cyc_q   <= '0;
            rnd_q   <= '0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cyc_q   <= cyc_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    // A finished block can be handed off and a new one loaded on the same
    // edge, so DONE also accepts when the consumer is taking the result.
    assign bus.in_ready = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        fsm_d   = fsm_q;
        cyc_d   = cyc_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        key_d   = key_q;

        case (fsm_q)
            S_RUN: begin
                // Round-unit inputs stay frozen until the last cycle of the
                // round so a multicycle round unit sees stable operands.
                if (cyc_q == CYC_LAST) begin
                    state_d = rnd_state_i;
                    key_d   = rnd_key_i;
                    cyc_d   = '0;
                    if (rnd_q == RND_FINAL) begin
                        fsm_d = S_DONE;
                        rnd_d = '0;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
            end
        endcase

        // Initial AddRoundKey is folded into the load.
        if (accept) begin
            state_d = bus.pt_i ^ bus.key_i;
            key_d   = bus.key_i;
            rnd_d   = 4'd1;
            cyc_d   = '0;
            fsm_d   = S_RUN;
        end
    end

    assign bus.out_valid = (fsm_q == S_DONE);
    assign bus.ct_o      = state_q;
    assign busy          = (fsm_q == S_RUN);
    assign rnd_state_o   = state_q;
    assign rnd_key_o     = key_q;
    assign rnd_num_o     = rnd_q;
    assign rnd_last_o    = (fsm_q == S_RUN) && (rnd_q == RND_FINAL);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer
module tb_aes_round_sequencer;

    localparam int NR   = 10;
    localparam int RC_A = 1;
    localparam int RC_B = 3;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_ST0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] JUNK     = 128'hdeadbeefcafef00d0123456789abcdef;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_sequencer_if a_if ();
    aes_round_sequencer_if b_if ();

    logic         a_busy, b_busy, a_rl, b_rl;
    logic [3:0]   a_rn, b_rn;
    logic [127:0] a_rs_o, a_rk_o, b_rs_o, b_rk_o;
    logic [127:0] a_rs_i = '0, a_rk_i = '0, b_rs_i = '0, b_rk_i = '0;

    aes_round_sequencer #(.NR(NR), .RND_CYC(RC_A)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if.slave), .busy(a_busy),
        .rnd_state_o(a_rs_o), .rnd_key_o(a_rk_o), .rnd_num_o(a_rn), .rnd_last_o(a_rl),
        .rnd_state_i(a_rs_i), .rnd_key_i(a_rk_i)
    );

    aes_round_sequencer #(.NR(NR), .RND_CYC(RC_B)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if.slave), .busy(b_busy),
        .rnd_state_o(b_rs_o), .rnd_key_o(b_rk_o), .rnd_num_o(b_rn), .rnd_last_o(b_rl),
        .rnd_state_i(b_rs_i), .rnd_key_i(b_rk_i)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // AES-128 reference (FIPS-197 arithmetic)
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = sbox[gb(s, 4 * (((i / 4) + (i % 4)) % 4) + (i % 4))];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [127:0] t;
        t = sub_shift(s);
        if (!last) t = mix_cols(t);
        return t ^ rk;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input int r);
        logic [7:0]  rc;
        logic [31:0] rot, t, n0, n1, n2, n3;
        rc = 8'h01;
        for (int j = 1; j < r; j++) rc = xt(rc);
        rot = {k[23:0], k[31:24]};
        t = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        s = pt ^ key;
        k = key;
        for (int r = 1; r <= NR; r++) begin
            k = key_exp(k, r);
            s = round_fn(s, k, r == NR);
        end
        return s;
    endfunction

    // External round units, settled on the falling edge from registered operands
    initial begin
        forever begin
            @(negedge clk);
            a_rk_i = key_exp(a_rk_o, int'(a_rn));
            a_rs_i = round_fn(a_rs_o, a_rk_i, a_rl);
            b_rk_i = key_exp(b_rk_o, int'(b_rn));
            b_rs_i = round_fn(b_rs_o, b_rk_i, b_rl);
        end
    end

    // Block-level model of instance A: one block in flight, ready NR*RC_A
    // cycles after its accept, held until the consumer takes it.
    bit           m_en = 1'b0, m_have = 1'b0, pre_ov, pre_ir, e_ov, e_busy, e_ir;
    int           m_now = 0, m_acc = 0, e_rn;
    logic [127:0] m_ct, m_init, m_key;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_have = 1'b0;
                m_en   = 1'b1;
            end else if (m_en) begin
                pre_ov = m_have && (m_now >= m_acc + NR * RC_A);
                pre_ir = !m_have || (pre_ov && a_if.out_ready);
                m_now++;
                if (pre_ov && a_if.out_ready) m_have = 1'b0;
                if (a_if.in_valid && pre_ir) begin
                    m_have = 1'b1;
                    m_acc  = m_now;
                    m_ct   = aes_ref(a_if.pt_i, a_if.key_i);
                    m_init = a_if.pt_i ^ a_if.key_i;
                    m_key  = a_if.key_i;
                end
            end
            @(negedge clk);
            if (m_en) begin
                e_ov   = m_have && (m_now >= m_acc + NR * RC_A);
                e_busy = m_have && !e_ov;
                e_ir   = !m_have || (e_ov && a_if.out_ready);
                e_rn   = e_busy ? (m_now - m_acc) / RC_A + 1 : 0;
                check_i("m.in_ready", int'(a_if.in_ready), int'(e_ir));
                check_i("m.out_valid", int'(a_if.out_valid), int'(e_ov));
                check_i("m.busy", int'(a_busy), int'(e_busy));
                check_i("m.rnd_num", int'(a_rn), e_rn);
                check_i("m.rnd_last", int'(a_rl), int'(e_busy && e_rn == NR));
                if (e_ov) check_v("m.ct", a_if.ct_o, m_ct);
                if (e_busy && m_now == m_acc) begin
                    check_v("m.state_load", a_rs_o, m_init);
                    check_v("m.key_load", a_rk_o, m_key);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] v_pt [3];
    logic [127:0] v_key [3];
    logic [127:0] v_ct [3];
    int lat, n;

    initial begin
        v_pt[0] = FIPS_PT; v_key[0] = FIPS_KEY; v_ct[0] = FIPS_CT;
        v_pt[1] = C1_PT;   v_key[1] = C1_KEY;   v_ct[1] = C1_CT;
        v_pt[2] = '0;      v_key[2] = '0;       v_ct[2] = ZERO_CT;

        rst = 1'b1;
        a_if.in_valid = 1'b0; a_if.pt_i = '0; a_if.key_i = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.pt_i = '0; b_if.key_i = '0; b_if.out_ready = 1'b0;
        repeat (3) step();
        check_i("rst.a_in_ready", int'(a_if.in_ready), 1);
        check_i("rst.a_out_valid", int'(a_if.out_valid), 0);
        check_i("rst.a_busy", int'(a_busy), 0);
        check_i("rst.a_rnd_num", int'(a_rn), 0);
        check_v("rst.a_ct", a_if.ct_o, '0);
        check_i("rst.b_in_ready", int'(b_if.in_ready), 1);
        check_v("rst.b_ct", b_if.ct_o, '0);
        rst = 1'b0;

        // FIPS vector, in_valid pulse during RUN, then 20 cycles of backpressure
        a_if.pt_i = FIPS_PT; a_if.key_i = FIPS_KEY; a_if.in_valid = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        check_v("fips.state_after_accept", a_rs_o, FIPS_ST0);
        check_i("fips.rnd_num_first", int'(a_rn), 1);
        lat = 0;
        while (!a_if.out_valid && lat < 100) begin
            if (lat == 3) begin a_if.in_valid = 1'b1; a_if.pt_i = JUNK; a_if.key_i = JUNK; end
            if (lat == 4) a_if.in_valid = 1'b0;
            step();
            lat++;
        end
        check_i("fips.latency", lat, NR);
        check_v("fips.ct", a_if.ct_o, FIPS_CT);
        repeat (20) step();
        check_i("hold.out_valid", int'(a_if.out_valid), 1);
        check_i("hold.in_ready", int'(a_if.in_ready), 0);
        check_v("hold.ct", a_if.ct_o, FIPS_CT);
        a_if.out_ready = 1'b1;
        step();
        a_if.out_ready = 1'b0;
        check_i("drain.out_valid", int'(a_if.out_valid), 0);
        check_i("drain.in_ready", int'(a_if.in_ready), 1);

        // Back-to-back, in_valid and out_ready held high
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_if.pt_i = v_pt[i]; a_if.key_i = v_key[i]; a_if.in_valid = 1'b1;
            n = 0;
            while (!a_if.in_ready && n < 100) begin step(); n++; end
            if (i > 0) begin
                check_i($sformatf("b2b.gap[%0d]", i), n, NR);
                check_v($sformatf("b2b.ct[%0d]", i - 1), a_if.ct_o, v_ct[i - 1]);
            end
            step();
        end
        a_if.in_valid = 1'b0;
        n = 0;
        while (!a_if.out_valid && n < 100) begin step(); n++; end
        check_i("b2b.gap[3]", n, NR);
        check_v("b2b.ct[2]", a_if.ct_o, v_ct[2]);
        step();
        a_if.out_ready = 1'b0;

        // Reset in round 5, then a fresh block
        a_if.pt_i = C1_PT; a_if.key_i = C1_KEY; a_if.in_valid = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        repeat (4) step();
        check_i("midrst.rnd_num_before", int'(a_rn), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_i("midrst.in_ready", int'(a_if.in_ready), 1);
        check_i("midrst.out_valid", int'(a_if.out_valid), 0);
        check_i("midrst.busy", int'(a_busy), 0);
        check_i("midrst.rnd_num", int'(a_rn), 0);
        check_v("midrst.ct", a_if.ct_o, '0);
        a_if.pt_i = '0; a_if.key_i = '0; a_if.in_valid = 1'b1; a_if.out_ready = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        n = 0;
        while (!a_if.out_valid && n < 100) begin step(); n++; end
        check_i("midrst.latency", n, NR);
        check_v("midrst.ct_after", a_if.ct_o, ZERO_CT);
        step();
        a_if.out_ready = 1'b0;

        // Three cycles per round on instance B
        b_if.pt_i = FIPS_PT; b_if.key_i = FIPS_KEY; b_if.in_valid = 1'b1;
        step();
        b_if.in_valid = 1'b0;
        for (int k = 0; k < NR * RC_B; k++) begin
            check_i($sformatf("b.rnd_num[%0d]", k), int'(b_rn), k / RC_B + 1);
            check_i($sformatf("b.rnd_last[%0d]", k), int'(b_rl), int'(k >= 27));
            check_i($sformatf("b.out_valid[%0d]", k), int'(b_if.out_valid), 0);
            step();
        end
        check_i("b.out_valid_at_30", int'(b_if.out_valid), 1);
        check_v("b.ct", b_if.ct_o, FIPS_CT);
        check_i("b.rnd_num_done", int'(b_rn), 0);
        check_i("b.rnd_last_done", int'(b_rl), 0);
        b_if.out_ready = 1'b1;
        step();
        b_if.out_ready = 1'b0;
        check_i("b.drain", int'(b_if.out_valid), 0);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1);
    end

endmodule
